// File: rtl/conv_gemm_col2im_writer.sv
// rtl/conv_gemm_col2im_writer.sv - GEMM C-tile to channel-major fmap writer with requant and saturation
// Optional feature macro: CONV_OUT_RELU_EN (negative saturated results are written as zero).
`ifndef DATA_W
`define DATA_W 8
`endif
`ifndef ACC_W
`define ACC_W 32
`endif
module conv_gemm_col2im_writer #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int M_TOTAL  = 3136,
  parameter int N_TOTAL  = 64,
  parameter int DATA_W_P = `DATA_W,
  parameter int ACC_W_P  = `ACC_W,
  parameter int SHIFT_W  = 5,
  parameter int ADDR_W   = $clog2(M_TOTAL*N_TOTAL)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tile_valid,
  output logic                               tile_ready,
  input  logic [31:0]                        tile_m_base,
  input  logic [31:0]                        tile_n_base,
  input  logic [$clog2(ROWS+1)-1:0]          tile_m_eff,
  input  logic [$clog2(COLS+1)-1:0]          tile_n_eff,
  input  logic signed [ACC_W_P-1:0]          C_tile [ROWS][COLS],
  input  logic [SHIFT_W-1:0]                 cfg_shift,
  output logic                               wr_en,
  output logic [ADDR_W-1:0]                  wr_addr,
  output logic signed [DATA_W_P-1:0]         wr_data,
  input  logic                               wr_ready,
  output logic                               busy,
  output logic                               tile_done,
  output logic                               err
);

  localparam int ME_W = $clog2(ROWS+1);
  localparam int NE_W = $clog2(COLS+1);
  localparam int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CI_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic signed [ACC_W_P:0] VMAX = (ACC_W_P+1)'((2**(DATA_W_P-1)) - 1);
  localparam logic signed [ACC_W_P:0] VMIN = -VMAX - 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_DONE} state_t;
  state_t state, state_nx;

  logic signed [ACC_W_P-1:0] tile_q [ROWS][COLS];
  logic [31:0]         m_base_q, n_base_q;
  logic [ME_W-1:0]     m_eff_q;
  logic [NE_W-1:0]     n_eff_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic [RI_W-1:0]     row;
  logic [CI_W-1:0]     col;
  logic [ADDR_W-1:0]   addr_q, col_base_q, start_addr;
  logic                err_q;

  logic        handshake, accept, last_row, last_col, last_write;
  logic        empty, range_bad, skip;
  logic [32:0] m_end, n_end;

  logic signed [ACC_W_P-1:0] acc;
  logic signed [ACC_W_P:0]   ext, rnd, sum, shr;
  logic signed [DATA_W_P-1:0] sat;

  assign handshake  = tile_valid & tile_ready;
  assign accept     = wr_en & wr_ready;
  assign last_row   = (ME_W'(row) == m_eff_q - ME_W'(1));
  assign last_col   = (NE_W'(col) == n_eff_q - NE_W'(1));
  assign last_write = accept & last_row & last_col;

  assign m_end      = {1'b0, m_base_q} + 33'(m_eff_q);
  assign n_end      = {1'b0, n_base_q} + 33'(n_eff_q);
  assign empty      = (m_eff_q == '0) || (n_eff_q == '0);
  assign range_bad  = (m_eff_q > ME_W'(ROWS)) || (n_eff_q > NE_W'(COLS)) ||
                      (m_end > 33'(M_TOTAL)) || (n_end > 33'(N_TOTAL));
  assign skip       = empty || range_bad;
  // Only a single constant multiply at tile start; per-element addresses are incremental.
  assign start_addr = ADDR_W'(n_base_q * 32'(M_TOTAL) + m_base_q);

  assign tile_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign tile_done  = (state == S_DONE);
  assign wr_en      = (state == S_WRITE);
  assign wr_addr    = wr_en ? addr_q : '0;
  assign wr_data    = wr_en ? sat : '0;
  assign err        = err_q;

  // State register; asynchronous reset abandons any tile in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: accept, range check, stream elements, one-cycle done.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (handshake) state_nx = S_CHECK;
      S_CHECK: state_nx = skip ? S_DONE : S_WRITE;
      S_WRITE: if (last_write) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Tile payload snapshot; only ever read while a tile is being written.
  always_ff @(posedge clk) begin
    if (handshake) tile_q <= C_tile;
  end

  // Tile descriptor snapshot taken at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_base_q <= '0;
      n_base_q <= '0;
      m_eff_q  <= '0;
      n_eff_q  <= '0;
      shift_q  <= '0;
    end else if (handshake) begin
      m_base_q <= tile_m_base;
      n_base_q <= tile_n_base;
      m_eff_q  <= tile_m_eff;
      n_eff_q  <= tile_n_eff;
      shift_q  <= cfg_shift;
    end
  end

  // Column-outer/row-inner walk with a running column base address; sticky range error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      addr_q     <= '0;
      col_base_q <= '0;
      err_q      <= 1'b0;
    end else if (state == S_CHECK) begin
      row        <= '0;
      col        <= '0;
      addr_q     <= start_addr;
      col_base_q <= start_addr;
      if (range_bad) err_q <= 1'b1;
    end else if (accept) begin
      if (last_row) begin
        row        <= '0;
        col        <= col + CI_W'(1);
        col_base_q <= col_base_q + ADDR_W'(M_TOTAL);
        addr_q     <= col_base_q + ADDR_W'(M_TOTAL);
      end else begin
        row    <= row + RI_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Round-half-up requantization at one extra bit, then saturate (and optionally clamp at zero).
  always_comb begin
    acc = tile_q[row][col];
    ext = {acc[ACC_W_P-1], acc};
    rnd = '0;
    if (shift_q != '0) rnd = (ACC_W_P+1)'(1) << (shift_q - SHIFT_W'(1));
    sum = ext + rnd;
    shr = sum >>> shift_q;
    if (shr > VMAX)      sat = DATA_W_P'(VMAX);
    else if (shr < VMIN) sat = DATA_W_P'(VMIN);
    else                 sat = shr[DATA_W_P-1:0];
`ifdef CONV_OUT_RELU_EN
    if (sat < 0) sat = '0;
`else
    sat = sat;
`endif
  end

endmodule

// File: doc/conv_gemm_col2im_writer.md
CONV_GEMM_COL2IM_WRITER -- requirements
Module: conv_gemm_col2im_writer

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- ROWS, 16, tile rows (M).
- COLS, 16, tile columns (N).
- M_TOTAL, 3136, output pixels (H_OUT*W_OUT).
- N_TOTAL, 64, output channels.
- DATA_W_P, DATA_W, output element width.
- ACC_W_P, ACC_W, accumulator width.
- SHIFT_W, 5, requant shift width.
- ADDR_W, $clog2(M_TOTAL*N_TOTAL), write address width.
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- tile_valid, in, 1, C tile offered.
- tile_ready, out, 1, block accepts a tile.
- tile_m_base, in, 32, global M index of tile row 0.
- tile_n_base, in, 32, global N index of tile col 0.
- tile_m_eff, in, $clog2(ROWS+1), valid rows.
- tile_n_eff, in, $clog2(COLS+1), valid cols.
- C_tile, in, [ROWS][COLS] x ACC_W_P signed, accumulated tile.
- cfg_shift, in, SHIFT_W, requant right shift.
- wr_en, out, 1, fmap write strobe.
- wr_addr, out, ADDR_W, channel-major address n*M_TOTAL+m.
- wr_data, out, DATA_W_P signed, requantized value.
- wr_ready, in, 1, sink accepts the write.
- busy, out, 1, high in any state except S_IDLE.
- tile_done, out, 1, one-cycle pulse per accepted tile.
- err, out, 1, sticky out-of-range flag.

Function
REQ-003 SHALL drive tile_ready=1 only in S_IDLE; handshake = tile_valid & tile_ready.
REQ-004 On handshake SHALL latch C_tile, bases, effs and cfg_shift into internal registers; later input changes SHALL have no effect on that tile.
REQ-005 State machine SHALL be S_IDLE -> (handshake) S_CHECK -> S_WRITE or S_DONE; S_WRITE -> (last write accepted) S_DONE; S_DONE -> S_IDLE.
REQ-006 S_CHECK SHALL go to S_DONE without writing when m_eff==0, n_eff==0, m_eff>ROWS, n_eff>COLS, m_base+m_eff>M_TOTAL or n_base+n_eff>N_TOTAL; the last four conditions SHALL also set err.
REQ-007 S_WRITE SHALL visit elements col-outer, row-inner (col 0..n_eff-1, row 0..m_eff-1), so addresses within one channel are contiguous ascending.
REQ-008 wr_addr SHALL equal (n_base+col)*M_TOTAL + (m_base+row), computed without dividers (running base plus increment).
REQ-009 wr_en SHALL be high throughout S_WRITE; an element is consumed on wr_en & wr_ready; while wr_ready=0, wr_addr and wr_data SHALL stay stable.
REQ-010 First wr_en SHALL occur 2 cycles after the handshake; with wr_ready held at 1, the tile SHALL take exactly m_eff*n_eff write cycles.
REQ-011 Requant: shift==0 -> v=acc; else v=(acc + 2^(shift-1)) >>> shift, with the add done at ACC_W_P+1 bits (no overflow).
REQ-012 v SHALL then saturate to [-2^(DATA_W_P-1), 2^(DATA_W_P-1)-1].
REQ-013 tile_done SHALL be high for exactly the one cycle in S_DONE; tile_ready SHALL return high in the next cycle.

Reset
REQ-014 rst_n low SHALL immediately force S_IDLE with outputs at reset values: wr_en=0, wr_addr=0, wr_data=0, tile_done=0, err=0, busy=0, tile_ready=1 once rst_n releases.
REQ-015 Reset mid-tile SHALL abandon the tile, with no further writes and no tile_done.
REQ-016 err SHALL clear only on reset.

Configuration
REQ-017 With CONV_OUT_RELU_EN defined, saturated negative values SHALL be written as 0; without it, the signed saturated value SHALL be written unchanged.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Tile m_base=0, n_base=0, 16x16, C[r][c]=r+16c, shift=0, wr_ready=1 -> 256 writes in 256 cycles; first write at handshake+2, addr 0 with data 0; write 17 has addr 3136+0, data 16; then one tile_done pulse.
- Last tile m_base=3120, m_eff=16, n_base=48, n_eff=16 -> final write addr 63*3136+3135=200703.
- Partial tile m_eff=3, n_eff=2, with wr_ready toggling 1,0,1,0 -> 6 writes, addr/data stable on stalled cycles, tile_done after the 6th accepted write.
- Requant: acc=1000, shift=3 -> 125; acc=-1000, shift=3 -> -125 (-0 with CONV_OUT_RELU_EN); acc=5000, shift=2 -> 127; acc=-70000, shift=0 -> -128 (0 with RELU).
- Bad tile m_base=3130, m_eff=16 -> no wr_en, err=1 sticky, tile_done pulses, next valid tile processed normally.
- rst_n asserted after 10 writes of a 16x16 tile -> wr_en=0 immediately, no tile_done, tile_ready=1 after release.
